// File: rtl/lottery_arbiter_n.sv
// lottery_arbiter_n: ticket-weighted lottery arbiter for NUM_REQ AHB masters.
// A free-running 16-bit LFSR picks a winner among the requesting masters,
// weighted by their programmable ticket counts. The grant is held until the
// owner drops its request, then one idle handover cycle follows.
// Optional feature macro: STARVE_GUARD_EN. When defined, every requestor has a
// saturating lost-draw counter. Once any requesting counter reaches
// STARVE_LIMIT, the lowest-index starved requester wins that draw.
module lottery_arbiter_n #(
    parameter int          NUM_REQ      = 4,
    parameter int          TKT_W        = 4,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       tkt_wr,
    input  logic [$clog2(NUM_REQ)-1:0] tkt_sel,
    input  logic [TKT_W-1:0]           tkt_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TOT_W  = TKT_W + IDX_W;
    localparam int PROD_W = TOT_W + 16;

    // Reject parameter sets the arbiter cannot support. An all-zero seed would lock the LFSR.
    if (NUM_REQ < 2 || NUM_REQ > 16 || SEED == 16'h0000 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("lottery_arbiter_n: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [TKT_W-1:0]    tkt [NUM_REQ];

    logic [NUM_REQ-1:0]  elig;
    logic [TOT_W-1:0]    total;
    logic [TOT_W-1:0]    acc;
    logic [TOT_W-1:0]    draw_w;
    logic [PROD_W-1:0]   prod;
    logic [IDX_W-1:0]    lottery_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                found;
    logic                draw_fire;

`ifdef STARVE_GUARD_EN
    localparam int             SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt [NUM_REQ];
`endif

    // Free-running Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, reloaded with SEED on reset.
    // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Ticket register file: software writes land at the edge, out-of-range indices are dropped.
    // NOTE: this file is a few flops rather than a RAM, so every entry is reset to a known ticket count of 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                tkt[i] <= TKT_W'(1);
            end
        end else if (tkt_wr && (int'(tkt_sel) < NUM_REQ)) begin
            tkt[tkt_sel] <= tkt_data;
        end
    end

    // Lottery draw: total the eligible tickets, scale the LFSR into [0, total), walk the prefix sums.
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches); blocking
    //       assignments are intended here because the prefix sum is accumulated in loop order.
    always_comb begin
        elig        = '0;
        total       = '0;
        acc         = '0;
        prod        = '0;
        draw_w      = '0;
        lottery_idx = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (tkt[i] != '0);
            if (elig[i]) begin
                total = total + TOT_W'(tkt[i]);
            end
        end
        prod   = PROD_W'(lfsr) * PROD_W'(total);
        draw_w = TOT_W'(prod >> 16);
        if (total == '0) begin
            // Every requester holds zero tickets: fall back to the lowest-index requester.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    found       = 1'b1;
                    lottery_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (elig[i]) begin
                    acc = acc + TOT_W'(tkt[i]);
                    if (!found && (acc > draw_w)) begin
                        found       = 1'b1;
                        lottery_idx = IDX_W'(i);
                    end
                end
            end
        end
    end

    // A draw happens only from IDLE, with enable high and at least one request pending.
    assign draw_fire = (state == IDLE) && enable && (|req);

`ifdef STARVE_GUARD_EN
    // Starvation override: the lowest-index requesting master at the lost-draw limit wins outright.
    always_comb begin
        win_idx = lottery_idx;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (starve_cnt[i] >= SC_MAX)) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Lost-draw counters: bump on a lost draw while requesting, clear on a win or when not requesting.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else if (draw_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((IDX_W'(i) == win_idx) || !req[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != SC_MAX) begin
                    starve_cnt[i] <= starve_cnt[i] + SC_W'(1);
                end
            end
        end
    end
`else
    // Pure lottery: the draw result is the winner.
    always_comb begin
        win_idx = lottery_idx;
    end
`endif

    // Grant FSM: IDLE draws, OWN holds until the owner releases, GAP idles the bus for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_fire) begin
                        grant       <= NUM_REQ'(1) << win_idx;
                        grant_valid <= 1'b1;
                        grant_id    <= win_idx;
                        state       <= OWN;
                    end
                end
                OWN: begin
                    if (!req[grant_id]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_id    <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lottery_arbiter_n.sv
// Testbench for lottery_arbiter_n: a cycle-level reference model predicts every
// draw from the lottery rules and queues the expected grant; a monitor pops and
// compares whenever the DUT presents a new grant.
module tb_lottery_arbiter_n;

    localparam int          NUM_REQ      = 4;
    localparam int          TKT_W        = 4;
    localparam logic [15:0] SEED         = 16'hACE1;
    localparam int          STARVE_LIMIT = 8;
    localparam int          IDX_W        = $clog2(NUM_REQ);

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic               tkt_wr;
    logic [IDX_W-1:0]   tkt_sel;
    logic [TKT_W-1:0]   tkt_data;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_id;

    always #5 clk = ~clk;

    lottery_arbiter_n #(
        .NUM_REQ     (NUM_REQ),
        .TKT_W       (TKT_W),
        .SEED        (SEED),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .tkt_wr     (tkt_wr),
        .tkt_sel    (tkt_sel),
        .tkt_data   (tkt_data),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NUM_REQ-1:0] grant;
        int                 id;
    } exp_t;

    exp_t               sb_q[$];
    int                 m_lfsr  = 0;
    int                 m_state = 0;   // 0 idle, 1 owned, 2 handover gap
    logic [NUM_REQ-1:0] m_grant = '0;
    int                 m_id    = 0;
    int                 m_tkt[NUM_REQ];
    int                 m_starve[NUM_REQ];

    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 'hFFFF;
    endfunction

    function automatic int ref_winner(input logic [NUM_REQ-1:0] r);
        int total;
        int w;
        int acc;
`ifdef STARVE_GUARD_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i] && m_starve[i] >= STARVE_LIMIT) return i;
        end
`endif
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) total += m_tkt[i];
        end
        if (total == 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r[i]) return i;
            end
        end
        w   = (m_lfsr * total) >> 16;
        acc = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) begin
                acc += m_tkt[i];
                if (acc > w) return i;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        int win;
        if (reset) begin
            m_lfsr  = SEED;
            m_state = 0;
            m_grant = '0;
            m_id    = 0;
            foreach (m_tkt[i]) m_tkt[i] = 1;
            foreach (m_starve[i]) m_starve[i] = 0;
        end else begin
            case (m_state)
                0: begin
                    if (enable && req != '0) begin
                        win = ref_winner(req);
`ifdef STARVE_GUARD_EN
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (i == win || !req[i]) m_starve[i] = 0;
                            else if (m_starve[i] < STARVE_LIMIT) m_starve[i]++;
                        end
`endif
                        m_grant      = '0;
                        m_grant[win] = 1'b1;
                        m_id         = win;
                        m_state      = 1;
                        sb_q.push_back('{grant: m_grant, id: win});
                    end
                end
                1: begin
                    if (!req[m_id]) begin
                        m_grant = '0;
                        m_id    = 0;
                        m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
            if (tkt_wr && int'(tkt_sel) < NUM_REQ) m_tkt[int'(tkt_sel)] = int'(tkt_data);
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- monitor ----------------
    logic [NUM_REQ-1:0] prev_grant = '0;
    logic               prev_valid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        check("valid_vs_model", grant_valid, (m_grant != '0));
        check("valid_eq_or_grant", grant_valid, |grant);
        check("grant_onehot", ($countones(grant) <= 1), 1);
        if (!grant_valid) check("id_zero_when_idle", grant_id, 0);
        if (grant_valid && (!prev_valid || grant != prev_grant)) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("sb_grant", grant, e.grant);
                check("sb_grant_id", grant_id, e.id);
            end
        end
        prev_grant = grant;
        prev_valid = grant_valid;
    end

    // ---------------- stimulus ----------------
    int win_cnt[NUM_REQ];
    int since0;
    int max_gap0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, ok, 1);
    endtask

    // Owner drops its line for one cycle, everyone else keeps requesting.
    task automatic release_owner(input logic [NUM_REQ-1:0] pat);
        req = pat & ~grant;
        tick();
        req = pat;
    endtask

    task automatic write_tkt(input int sel, input int val);
        tkt_wr   = 1'b1;
        tkt_sel  = IDX_W'(sel);
        tkt_data = TKT_W'(val);
        tick();
        tkt_wr   = 1'b0;
    endtask

    task automatic run_draws(input logic [NUM_REQ-1:0] pat, input int n, input int max_hold);
        logic ok;
        foreach (win_cnt[i]) win_cnt[i] = 0;
        since0   = 0;
        max_gap0 = 0;
        req      = pat;
        for (int d = 0; d < n; d++) begin
            wait_grant("draw_timeout", ok);
            if (!ok) return;
            win_cnt[grant_id]++;
            since0++;
            if (grant_id == 0) begin
                if (since0 > max_gap0) max_gap0 = since0;
                since0 = 0;
            end
            repeat ($urandom_range(max_hold, 0)) tick();
            release_owner(pat);
        end
        if (since0 > max_gap0) max_gap0 = since0;
    endtask

    task automatic go_idle();
        req = '0;
        repeat (3) tick();
    endtask

    initial begin
        logic ok;
        reset    = 1'b1;
        enable   = 1'b0;
        req      = '0;
        tkt_wr   = 1'b0;
        tkt_sel  = '0;
        tkt_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_valid", grant_valid, 0);
        check("rst_id", grant_id, 0);

        // Single requester: one-cycle latency, hold, release, handover gap.
        enable = 1'b1;
        req    = 4'b0100;
        tick();
        check("single_grant", grant, 4'b0100);
        check("single_id", grant_id, 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("single_hold", grant, 4'b0100);
        end
        req = '0;
        tick();
        check("single_release", grant, 0);
        req = 4'b0100;
        tick();
        check("single_gap", grant_valid, 0);
        tick();
        check("single_regrant", grant, 4'b0100);
        go_idle();

        // enable low blocks new draws; reset mid-grant clears at that edge.
        enable = 1'b0;
        req    = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("disabled_no_grant", grant, 0);
        end
        enable = 1'b1;
        tick();
        check("enable_grant", grant, 4'b0001);
        tick();
        reset = 1'b1;
        tick();
        check("midgrant_rst_grant", grant, 0);
        check("midgrant_rst_valid", grant_valid, 0);
        check("midgrant_rst_id", grant_id, 0);
        reset = 1'b0;
        go_idle();

        // Zero tickets everywhere: lowest requester wins; a mid-grant write applies at the next draw.
        for (int i = 0; i < NUM_REQ; i++) write_tkt(i, 0);
        run_draws(4'b0110, 5, 2);
        check("zero_tkt_lowest", win_cnt[1], 5);
        wait_grant("zero_tkt_wait", ok);
        check("zero_tkt_owner", grant, 4'b0010);
        write_tkt(2, 5);
        check("tkt_write_keeps_grant", grant, 4'b0010);
        tick();
        check("tkt_write_keeps_grant2", grant, 4'b0010);
        release_owner(4'b0110);
        wait_grant("tkt_write_wait", ok);
        check("tkt_write_next_draw", grant, 4'b0100);
        go_idle();

        // All weight on master 3.
        write_tkt(0, 0);
        write_tkt(1, 0);
        write_tkt(2, 0);
        write_tkt(3, 15);
        run_draws(4'b1111, 50, 2);
`ifndef STARVE_GUARD_EN
        check("heavy_m3_wins", win_cnt[3], 50);
`endif
        go_idle();

        // Tickets {1,3}: master 1 should take roughly three quarters of the draws.
        write_tkt(0, 1);
        write_tkt(1, 3);
        write_tkt(2, 0);
        write_tkt(3, 0);
        run_draws(4'b0011, 4000, 1);
        check_range("m1_share_70_80pct", win_cnt[1], 2800, 3200);
        go_idle();

`ifdef STARVE_GUARD_EN
        // Tickets {1,15}: the guard must force master 0 in at least every ninth draw.
        write_tkt(1, 15);
        run_draws(4'b0011, 300, 1);
        check_range("starve_gap_m0", max_gap0, 1, 9);
        go_idle();
`endif

        // Random traffic with ticket writes, enable toggling and the odd reset.
        for (int c = 0; c < 2000; c++) begin
            enable = ($urandom_range(9, 0) != 0);
            if ($urandom_range(3, 0) == 0) req = NUM_REQ'($urandom_range(15, 0));
            tkt_wr   = ($urandom_range(7, 0) == 0);
            tkt_sel  = IDX_W'($urandom_range(3, 0));
            tkt_data = TKT_W'($urandom_range(15, 0));
            reset    = ($urandom_range(299, 0) == 0);
            tick();
        end
        reset  = 1'b0;
        tkt_wr = 1'b0;
        req    = '0;
        repeat (5) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
